// File: rtl/seq_calculator_core.sv
// Sequential calculator datapath: one-cycle ADD/SUB/logic ops, iterative shift-add MUL
// and restoring DIV, with a start/done handshake and registered result and status flags.
module seq_calculator_core #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [2:0]           operation,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t               r_state;
  logic                 r_isDiv;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_quo;
  logic [WIDTH-1:0]     r_divisor;

  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_diff;
  logic [2*WIDTH-1:0]   w_quick;
  logic [2*WIDTH-1:0]   w_accNext;
  logic [WIDTH:0]       w_shift;
  logic [WIDTH:0]       w_trial;
  logic                 w_fits;
  logic [WIDTH-1:0]     w_remNext;
  logic [WIDTH-1:0]     w_quoNext;
  logic                 w_needsCalc;

  // Bit WIDTH of the widened sum/difference is the carry/borrow the display path expects.
  always_comb begin
    w_sum   = {1'b0, A} + {1'b0, B};
    w_diff  = {1'b0, A} - {1'b0, B};
    w_quick = '0;
    case (operation)
      OP_ADD:  w_quick = {{(WIDTH-1){1'b0}}, w_sum};
      OP_SUB:  w_quick = {{(WIDTH-1){1'b0}}, w_diff};
      OP_DIV:  w_quick = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
      OP_AND:  w_quick = {{WIDTH{1'b0}}, A & B};
      OP_OR:   w_quick = {{WIDTH{1'b0}}, A | B};
      OP_XOR:  w_quick = {{WIDTH{1'b0}}, A ^ B};
      OP_NOT:  w_quick = {{WIDTH{1'b0}}, ~A};
      default: w_quick = '0;
    endcase
  end

  assign w_needsCalc = (operation == OP_MUL) || ((operation == OP_DIV) && (B != '0));

  // One shift-add step and one restoring trial-subtract step; the final step feeds the result directly.
  assign w_accNext = r_acc + (r_mplier[0] ? r_mcand : {(2*WIDTH){1'b0}});
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_trial   = w_shift - {1'b0, r_divisor};
  assign w_fits    = ~w_trial[WIDTH];
  assign w_remNext = w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quoNext = {r_quo[WIDTH-2:0], w_fits};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_isDiv     <= 1'b0;
      r_cnt       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_divisor   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            r_isDiv     <= (operation == OP_DIV);
            r_cnt       <= '0;
            r_mcand     <= {{WIDTH{1'b0}}, A};
            r_mplier    <= B;
            r_acc       <= '0;
            r_rem       <= '0;
            r_quo       <= A;
            r_divisor   <= B;
            if (w_needsCalc) begin
              r_state <= S_CALC;
            end else begin
              r_state     <= S_DONE;
              done        <= 1'b1;
              result      <= w_quick;
              remainder   <= (operation == OP_DIV) ? A : '0;
              div_by_zero <= (operation == OP_DIV);
            end
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_isDiv) begin
            r_rem <= w_remNext;
            r_quo <= w_quoNext;
          end else begin
            r_acc    <= w_accNext;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
          end
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state <= S_DONE;
            done    <= 1'b1;
            if (r_isDiv) begin
              result    <= {{WIDTH{1'b0}}, w_quoNext};
              remainder <= w_remNext;
            end else begin
              result    <= w_accNext;
              remainder <= '0;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_calculator_core.sv
// Directed testbench for seq_calculator_core at WIDTH=8: latency, arithmetic results,
// status flags, ignored starts while busy, and asynchronous reset abort.
module tb_seq_calculator_core;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [2:0]  operation;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int nChecks;
  int nFails;

  seq_calculator_core #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .A           (A),
    .B           (B),
    .operation   (operation),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request, scrambles the inputs right after acceptance, and returns at the
  // falling edge of the done cycle (lat = 0 if done never arrived).
  task automatic runOp(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       output int lat, output int busyCycles);
    @(negedge clk);
    A = a; B = b; operation = op; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = ~a; B = ~b; operation = op ^ 3'b001;
    lat = 0;
    busyCycles = 0;
    for (int k = 1; k <= 40; k++) begin
      if (busy) busyCycles++;
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; A = '0; B = '0; operation = '0;
    repeat (3) @(negedge clk);
    nChecks++;
    if ({busy, done, result, remainder, div_by_zero} !== 27'd0) begin
      nFails++;
      $display("[TB] FAIL reset_outputs: got busy=%0b done=%0b result=%h rem=%h dbz=%0b, want all 0",
               busy, done, result, remainder, div_by_zero);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    int lat, bc;
    runOp(3'b000, 8'd200, 8'd100, lat, bc);
    nChecks++;
    if (lat !== 1) begin nFails++; $display("[TB] FAIL add_latency: got %0d want 1", lat); end
    nChecks++;
    if (result !== 16'h012C) begin nFails++; $display("[TB] FAIL add_result: got %h want 012c", result); end
    nChecks++;
    if (remainder !== 8'd0) begin nFails++; $display("[TB] FAIL add_remainder: got %h want 00", remainder); end
    @(negedge clk);
    nChecks++;
    if ({busy, done} !== 2'b00) begin
      nFails++; $display("[TB] FAIL add_after_done: got busy=%0b done=%0b want 0 0", busy, done);
    end
    nChecks++;
    if (result !== 16'h012C) begin nFails++; $display("[TB] FAIL add_hold: got %h want 012c", result); end
  endtask

  task automatic test_sub();
    int lat, bc;
    runOp(3'b001, 8'd5, 8'd9, lat, bc);
    nChecks++;
    if (lat !== 1 || result !== 16'h01FC) begin
      nFails++; $display("[TB] FAIL sub_borrow: got lat=%0d result=%h want lat=1 result=01fc", lat, result);
    end
    runOp(3'b001, 8'd9, 8'd5, lat, bc);
    nChecks++;
    if (result !== 16'h0004) begin nFails++; $display("[TB] FAIL sub_plain: got %h want 0004", result); end
  endtask

  task automatic test_mul();
    int lat, bc;
    runOp(3'b010, 8'd255, 8'd255, lat, bc);
    nChecks++;
    if (lat !== 9) begin nFails++; $display("[TB] FAIL mul_latency: got %0d want 9", lat); end
    nChecks++;
    if (bc !== 9) begin nFails++; $display("[TB] FAIL mul_busy_cycles: got %0d want 9", bc); end
    nChecks++;
    if (result !== 16'hFE01) begin nFails++; $display("[TB] FAIL mul_max: got %h want fe01", result); end
    runOp(3'b010, 8'd0, 8'd77, lat, bc);
    nChecks++;
    if (result !== 16'h0000 || lat !== 9) begin
      nFails++; $display("[TB] FAIL mul_zero: got lat=%0d result=%h want lat=9 result=0000", lat, result);
    end
    runOp(3'b010, 8'd13, 8'd11, lat, bc);
    nChecks++;
    if (result !== 16'd143) begin nFails++; $display("[TB] FAIL mul_small: got %0d want 143", result); end
  endtask

  task automatic test_div();
    int lat, bc;
    runOp(3'b011, 8'd200, 8'd7, lat, bc);
    nChecks++;
    if (lat !== 9) begin nFails++; $display("[TB] FAIL div_latency: got %0d want 9", lat); end
    nChecks++;
    if (result !== 16'h001C || remainder !== 8'd4 || div_by_zero !== 1'b0) begin
      nFails++; $display("[TB] FAIL div_result: got q=%h r=%0d dbz=%0b want q=001c r=4 dbz=0",
                         result, remainder, div_by_zero);
    end
    runOp(3'b011, 8'd13, 8'd0, lat, bc);
    nChecks++;
    if (lat !== 1) begin nFails++; $display("[TB] FAIL div0_latency: got %0d want 1", lat); end
    nChecks++;
    if (result !== 16'h00FF || remainder !== 8'd13 || div_by_zero !== 1'b1) begin
      nFails++; $display("[TB] FAIL div0_result: got q=%h r=%0d dbz=%0b want q=00ff r=13 dbz=1",
                         result, remainder, div_by_zero);
    end
    repeat (2) @(negedge clk);
    nChecks++;
    if (div_by_zero !== 1'b1) begin nFails++; $display("[TB] FAIL div0_hold: got dbz=%0b want 1", div_by_zero); end
    runOp(3'b000, 8'd3, 8'd4, lat, bc);
    nChecks++;
    if (div_by_zero !== 1'b0 || remainder !== 8'd0 || result !== 16'd7) begin
      nFails++; $display("[TB] FAIL div0_clear: got dbz=%0b r=%0d result=%0d want dbz=0 r=0 result=7",
                         div_by_zero, remainder, result);
    end
    runOp(3'b011, 8'd255, 8'd1, lat, bc);
    nChecks++;
    if (result !== 16'h00FF || remainder !== 8'd0) begin
      nFails++; $display("[TB] FAIL div_by_one: got q=%h r=%0d want q=00ff r=0", result, remainder);
    end
  endtask

  task automatic test_logic();
    int lat, bc;
    logic [2:0]  ops [4];
    logic [15:0] exps [4];
    ops  = '{3'b100, 3'b101, 3'b110, 3'b111};
    exps = '{16'h0048, 16'h00DE, 16'h0096, 16'h0035};
    for (int i = 0; i < 4; i++) begin
      runOp(ops[i], 8'hCA, 8'h5C, lat, bc);
      nChecks++;
      if (lat !== 1 || result !== exps[i]) begin
        nFails++; $display("[TB] FAIL logic_op%0d: got lat=%0d result=%h want lat=1 result=%h",
                           ops[i], lat, result, exps[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int doneCount, firstDone;
    @(negedge clk);
    A = 8'd12; B = 8'd10; operation = 3'b010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    doneCount = 0;
    firstDone = 0;
    for (int k = 1; k <= 15; k++) begin
      if (k == 3) begin
        A = 8'd1; B = 8'd2; operation = 3'b000; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        doneCount++;
        if (firstDone == 0) firstDone = k;
      end
      if (k == 9) begin
        nChecks++;
        if (result !== 16'd120) begin nFails++; $display("[TB] FAIL busy_ignore_result: got %0d want 120", result); end
      end
      @(negedge clk);
    end
    nChecks++;
    if (doneCount !== 1 || firstDone !== 9) begin
      nFails++; $display("[TB] FAIL busy_ignore_done: got count=%0d at=%0d want count=1 at=9", doneCount, firstDone);
    end
  endtask

  task automatic test_reset_abort();
    int lat, bc, doneCount;
    @(negedge clk);
    A = 8'd200; B = 8'd7; operation = 3'b011; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    nChecks++;
    if ({busy, done, result, remainder, div_by_zero} !== 27'd0) begin
      nFails++; $display("[TB] FAIL abort_outputs: got busy=%0b done=%0b result=%h rem=%h dbz=%0b want all 0",
                         busy, done, result, remainder, div_by_zero);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    doneCount = 0;
    for (int k = 0; k < 12; k++) begin
      if (done || busy) doneCount++;
      @(negedge clk);
    end
    nChecks++;
    if (doneCount !== 0 || result !== 16'd0) begin
      nFails++; $display("[TB] FAIL abort_no_done: got activity=%0d result=%h want 0 0000", doneCount, result);
    end
    runOp(3'b000, 8'd1, 8'd1, lat, bc);
    nChecks++;
    if (lat !== 1 || result !== 16'd2) begin
      nFails++; $display("[TB] FAIL abort_recover: got lat=%0d result=%0d want lat=1 result=2", lat, result);
    end
  endtask

  initial begin
    nChecks = 0;
    nFails  = 0;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_div();
    test_logic();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
